// File: rtl/vst_strided_unit.sv
// Strided vector-store engine.
// Streams VRF elements to memory at base + i*stride, in index order.
module vst_strided_unit #(
  parameter int VLMAX        = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int VREG_WIDTH   = 5,
  parameter int STRIDE_WIDTH = 16,
  parameter int CNT_WIDTH    = $clog2(VLMAX) + 1,
  parameter int VRF_AW       = VREG_WIDTH + $clog2(VLMAX)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [VREG_WIDTH-1:0]   req_vr,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [STRIDE_WIDTH-1:0] req_stride,
  input  logic [CNT_WIDTH-1:0]    req_vl,
  output logic                    vrf_rd_en,
  output logic [VRF_AW-1:0]       vrf_rd_addr,
  input  logic [DATA_WIDTH-1:0]   vrf_rd_data,
  output logic                    mem_wr_valid,
  input  logic                    mem_wr_ready,
  output logic [ADDR_WIDTH-1:0]   mem_wr_addr,
  output logic [DATA_WIDTH-1:0]   mem_wr_data,
  output logic                    done
);

  localparam int LW = $clog2(VLMAX);
  localparam logic [CNT_WIDTH-1:0] VLMAX_C = CNT_WIDTH'(VLMAX);
  localparam logic [CNT_WIDTH-1:0] ONE_C   = CNT_WIDTH'(1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t state_q, state_d;

  logic [VREG_WIDTH-1:0] vr_q;
  logic [ADDR_WIDTH-1:0] acc_q;
  logic [ADDR_WIDTH-1:0] stride_q;
  logic [CNT_WIDTH-1:0]  vl_q;
  logic [CNT_WIDTH-1:0]  i_q;
  logic                  inflight_q;
  logic [ADDR_WIDTH-1:0] fl_addr_q;
  logic                  done_q;

  logic [ADDR_WIDTH-1:0] f_addr [2];
  logic [DATA_WIDTH-1:0] f_data [2];
  logic                  wp_q, rp_q;
  logic [1:0]            cnt_q;

  logic                  accept, issue, pop, push, fin, done_d, credit;
  logic [2:0]            used;
  logic [CNT_WIDTH-1:0]  vl_eff;
  logic [ADDR_WIDTH-1:0] stride_sx;

  assign vl_eff = (req_vl > VLMAX_C) ? VLMAX_C : req_vl;
  assign stride_sx = {{(ADDR_WIDTH-STRIDE_WIDTH){req_stride[STRIDE_WIDTH-1]}},
                      req_stride};

  assign mem_wr_valid = (cnt_q != 2'd0);
  assign pop  = mem_wr_valid & mem_wr_ready;
  assign push = inflight_q;
  assign used = {1'b0, cnt_q} + {2'b0, inflight_q};
  assign credit = used < (3'd2 + {2'b0, pop});
  assign fin = pop & (cnt_q == 2'd1) & ~inflight_q;

  assign req_ready   = (state_q == IDLE);
  assign vrf_rd_en   = issue;
  assign vrf_rd_addr = issue ? VRF_AW'({vr_q, i_q[LW-1:0]}) : '0;
  assign mem_wr_addr = mem_wr_valid ? f_addr[rp_q] : '0;
  assign mem_wr_data = mem_wr_valid ? f_data[rp_q] : '0;
  assign done        = done_q;

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // next state, read issue and completion decode
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    issue   = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          accept = 1'b1;
          if (vl_eff == '0) done_d  = 1'b1;
          else              state_d = RUN;
        end
      end
      RUN: begin
        if (credit) begin
          issue = 1'b1;
          if (i_q == vl_q - ONE_C) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (fin) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // command latch, element index and stride accumulator
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vr_q       <= '0;
      acc_q      <= '0;
      stride_q   <= '0;
      vl_q       <= '0;
      i_q        <= '0;
      inflight_q <= 1'b0;
      fl_addr_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      if (accept) begin
        vr_q     <= req_vr;
        acc_q    <= req_addr;
        stride_q <= stride_sx;
        vl_q     <= vl_eff;
        i_q      <= '0;
      end else if (issue) begin
        i_q   <= i_q + ONE_C;
        acc_q <= acc_q + stride_q;
      end
      inflight_q <= issue;
      if (issue) fl_addr_q <= acc_q;
      done_q <= done_d;
    end
  end

  // fifo pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q  <= 1'b0;
      rp_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      if (push) wp_q <= ~wp_q;
      if (pop)  rp_q <= ~rp_q;
      cnt_q <= cnt_q + 2'(push) - 2'(pop);
    end
  end

  // fifo storage: returned data paired with its address
  always_ff @(posedge clk) begin
    if (push) begin
      f_addr[wp_q] <= fl_addr_q;
      f_data[wp_q] <= vrf_rd_data;
    end
  end

endmodule

// File: tb/tb_vst_strided_unit.sv
// Directed bench for vst_strided_unit.
// Logs reads/writes/done per cycle and checks them against expectations.
module tb_vst_strided_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_vr;
  logic [31:0] req_addr;
  logic [15:0] req_stride;
  logic [5:0]  req_vl;
  logic        vrf_rd_en;
  logic [9:0]  vrf_rd_addr;
  logic [31:0] vrf_rd_data;
  logic        mem_wr_valid;
  logic        mem_wr_ready;
  logic [31:0] mem_wr_addr;
  logic [31:0] mem_wr_data;
  logic        done;

  vst_strided_unit dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_vr(req_vr), .req_addr(req_addr),
    .req_stride(req_stride), .req_vl(req_vl),
    .vrf_rd_en(vrf_rd_en), .vrf_rd_addr(vrf_rd_addr),
    .vrf_rd_data(vrf_rd_data),
    .mem_wr_valid(mem_wr_valid), .mem_wr_ready(mem_wr_ready),
    .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .done(done)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nmis = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int nrdy = 0;
  int stall_bad = 0;
  logic prev_stall = 1'b0;
  logic [31:0] prev_a = '0;
  logic [31:0] prev_d = '0;

  logic [9:0]  rd_a [$];
  int          rd_c [$];
  logic [31:0] wr_a [$];
  logic [31:0] wr_d [$];
  int          wr_c [$];
  int          dn_c [$];
  logic        dn_r [$];

  function automatic logic [31:0] pat(input logic [9:0] a);
    logic [31:0] w;
    w = {22'h0, a};
    return 32'hC0DE0000 ^ w ^ (w << 20);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk)
    vrf_rd_data <= vrf_rd_en ? pat(vrf_rd_addr) : 32'hDEADBEEF;

  always @(negedge clk) begin
    if (!rst) begin
      if (req_valid && req_ready) acc_cyc <= cyc;
      if (vrf_rd_en) begin
        rd_a.push_back(vrf_rd_addr);
        rd_c.push_back(cyc);
      end
      if (mem_wr_valid && mem_wr_ready) begin
        wr_a.push_back(mem_wr_addr);
        wr_d.push_back(mem_wr_data);
        wr_c.push_back(cyc);
      end
      if (done) begin
        dn_c.push_back(cyc);
        dn_r.push_back(req_ready);
      end
      if (!req_ready) nrdy <= nrdy + 1;
      if (prev_stall && (mem_wr_addr != prev_a || mem_wr_data != prev_d))
        stall_bad <= stall_bad + 1;
      prev_stall <= mem_wr_valid && !mem_wr_ready;
      prev_a <= mem_wr_addr;
      prev_d <= mem_wr_data;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    rd_a.delete(); rd_c.delete();
    wr_a.delete(); wr_d.delete(); wr_c.delete();
    dn_c.delete(); dn_r.delete();
  endtask

  task automatic send(input logic [4:0] vr, input logic [31:0] a,
                      input logic [15:0] s, input logic [5:0] vl);
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_vr = vr; req_addr = a; req_stride = s; req_vl = vl;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (dn_c.size() == 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    chk({tag, "_timeout"}, 64'(dn_c.size() != 0), 64'd1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic chk_stream(input string t, input int vr,
                            input logic [31:0] base, input logic [31:0] s,
                            input int n, input bit timing);
    logic [31:0] ea;
    logic [9:0]  ra;
    chk({t, "_nwr"}, 64'(wr_a.size()), 64'(n));
    chk({t, "_nrd"}, 64'(rd_a.size()), 64'(n));
    for (int k = 0; k < n; k++) begin
      ea = base + s * k;
      ra = 10'(vr * 32 + k);
      if (k < wr_a.size()) begin
        chk({t, "_wa"}, 64'(wr_a[k]), 64'(ea));
        chk({t, "_wd"}, 64'(wr_d[k]), 64'(pat(ra)));
        if (timing) chk({t, "_wc"}, 64'(wr_c[k] - acc_cyc), 64'(3 + k));
      end
      if (k < rd_a.size()) begin
        chk({t, "_ra"}, 64'(rd_a[k]), 64'(ra));
        if (timing) chk({t, "_rc"}, 64'(rd_c[k] - acc_cyc), 64'(1 + k));
      end
    end
    chk({t, "_ndone"}, 64'(dn_c.size()), 64'd1);
    if (dn_c.size() > 0) begin
      chk({t, "_done_rdy"}, 64'(dn_r[0]), 64'd1);
      if (timing) chk({t, "_done_c"}, 64'(dn_c[0] - acc_cyc), 64'(n + 3));
    end
  endtask

  task automatic chk_reset_outs(input string t);
    chk({t, "_ready"}, 64'(req_ready), 64'd1);
    chk({t, "_rden"}, 64'(vrf_rd_en), 64'd0);
    chk({t, "_rdaddr"}, 64'(vrf_rd_addr), 64'd0);
    chk({t, "_wvalid"}, 64'(mem_wr_valid), 64'd0);
    chk({t, "_waddr"}, 64'(mem_wr_addr), 64'd0);
    chk({t, "_wdata"}, 64'(mem_wr_data), 64'd0);
    chk({t, "_done"}, 64'(done), 64'd0);
  endtask

  initial begin
    int n0, s0, nr, n;
    rst = 1'b1;
    req_valid = 1'b0;
    req_vr = '0; req_addr = '0; req_stride = '0; req_vl = '0;
    mem_wr_ready = 1'b1;
    #2;
    chk_reset_outs("rst0");
    @(posedge clk); #1;
    rst = 1'b0;

    // T1 basic unit-ish stride
    clr();
    send(5'd2, 32'h100, 16'd4, 6'd4);
    wait_done("t1", 40);
    chk_stream("t1", 2, 32'h100, 32'd4, 4, 1'b1);

    // T2 negative stride
    clr();
    send(5'd5, 32'h1000, 16'hFFF8, 6'd3);
    wait_done("t2", 40);
    chk_stream("t2", 5, 32'h1000, 32'hFFFFFFF8, 3, 1'b1);

    // T3 backpressure cycles 3-8
    clr();
    s0 = stall_bad;
    mem_wr_ready = 1'b0;
    send(5'd2, 32'h100, 16'd4, 6'd4);
    repeat (8) @(posedge clk);
    #1;
    mem_wr_ready = 1'b1;
    nr = 0;
    for (int k = 0; k < rd_c.size(); k++)
      if (rd_c[k] - acc_cyc <= 8) nr++;
    chk("t3_rd_stall", 64'(nr), 64'd2);
    chk("t3_wr_stall", 64'(wr_a.size()), 64'd0);
    wait_done("t3", 60);
    chk_stream("t3", 2, 32'h100, 32'd4, 4, 1'b0);
    chk("t3_hold", 64'(stall_bad - s0), 64'd0);

    // T4 zero length
    clr();
    n0 = nrdy;
    send(5'd3, 32'h200, 16'd4, 6'd0);
    wait_done("t4", 20);
    chk("t4_nrd", 64'(rd_a.size()), 64'd0);
    chk("t4_nwr", 64'(wr_a.size()), 64'd0);
    chk("t4_ndone", 64'(dn_c.size()), 64'd1);
    if (dn_c.size() > 0)
      chk("t4_done_c", 64'(dn_c[0] - acc_cyc), 64'd1);
    chk("t4_ready", 64'(nrdy - n0), 64'd0);

    // T5 vl clamped to VLMAX with address wrap
    clr();
    send(5'd1, 32'hFFFFFFFC, 16'd4, 6'd40);
    wait_done("t5", 100);
    chk_stream("t5", 1, 32'hFFFFFFFC, 32'd4, 32, 1'b1);

    // T6 reset mid-run, then a fresh command
    clr();
    send(5'd2, 32'h100, 16'd4, 6'd4);
    n = 0;
    while (wr_a.size() < 2 && n < 20) begin
      @(posedge clk);
      n++;
    end
    chk("t6_two_wr", 64'(wr_a.size() >= 2), 64'd1);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk_reset_outs("t6_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    clr();
    send(5'd2, 32'h100, 16'd4, 6'd4);
    wait_done("t6b", 40);
    chk_stream("t6b", 2, 32'h100, 32'd4, 4, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
